// File: rtl/pe_pkg.sv
// Shared types, defaults and the requantise helper for the convolution PE.
package pe_pkg;

  localparam int unsigned TAPS_DEF  = 25;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned WW_DEF    = 8;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned SHIFT_W   = 5;

  // Requantised output range (uint8)
  localparam longint QMIN = 0;
  localparam longint QMAX = 255;

  // Per-beat post-processing controls; they travel down the pipe with the beat
  typedef struct packed {
    logic               relu;
    logic               quan;
    logic [SHIFT_W-1:0] shift;
  } cfg_t;

  typedef enum logic [0:0] {
    StFirst,
    StAccum
  } acc_state_e;

  typedef struct packed {
    logic [7:0] q;
    logic       sat;
  } quant_t;

  // Round-half-up right shift followed by a clamp to [QMIN, QMAX].
  // Done at 64 bits, which gives at least one guard bit for any ACC_W <= 63.
  function automatic quant_t requant(input longint r, input logic [SHIFT_W-1:0] shift);
    longint q;
    logic   rb;
    quant_t res;
    rb = (shift == '0) ? 1'b0 : r[shift - 5'd1];
    q  = (r >>> shift) + longint'(rb);
    res.sat = 1'b0;
    if (q < QMIN) begin
      q       = QMIN;
      res.sat = 1'b1;
    end else if (q > QMAX) begin
      q       = QMAX;
      res.sat = 1'b1;
    end
    res.q = q[7:0];
    return res;
  endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Balanced adder tree over TAPS signed products, registered once at the output.
module pe_adder_tree
  import pe_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TAPS-1:0][ACC_W-1:0]  i_prod,
  output logic signed [ACC_W-1:0]     o_sum
);

  localparam int unsigned LEVELS = $clog2(TAPS);
  localparam int unsigned LEAVES = 1 << LEVELS;

  // Pairwise reduction, level by level; unused leaves are zero.
  // Two's complement add is sign-agnostic, so packed (unsigned) nodes are fine.
  function automatic logic [ACC_W-1:0] tree_sum(input logic [TAPS-1:0][ACC_W-1:0] prod);
    logic [LEAVES-1:0][ACC_W-1:0] node;
    node = '0;
    for (int i = 0; i < TAPS; i++) begin
      node[i] = prod[i];
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < (LEAVES >> (l + 1)); i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    return node[0];
  endfunction

  logic [ACC_W-1:0] w_sum;

  assign w_sum = tree_sum(i_prod);

  // Pipeline register for the partial sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sum <= '0;
    end else begin
      o_sum <= w_sum;
    end
  end

endmodule

// File: rtl/pe_conv_mac.sv
// Convolution PE: TAPS products -> adder tree -> channel accumulator -> ReLU/requantise.
// Four register stages, II=1, no stall.
module pe_conv_mac
  import pe_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned WW    = WW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [TAPS*DW-1:0]      in_if,
  input  logic [TAPS*WW-1:0]      in_w,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    cfg_relu,
  input  logic                    cfg_quan,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  output logic                    out_valid,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_sat
);

  localparam int unsigned PW = DW + WW + 1;  // exact product width

  // ---------------- S1: multiplier array ----------------
  logic [TAPS-1:0][ACC_W-1:0] w_mul;

  for (genvar k = 0; k < TAPS; k++) begin : g_mul
    logic signed [DW:0]    w_a;
    logic signed [WW-1:0]  w_b;
    logic signed [PW-1:0]  w_p;
    assign w_a      = {1'b0, in_if[k*DW +: DW]};
    assign w_b      = in_w[k*WW +: WW];
    assign w_p      = w_a * w_b;
    assign w_mul[k] = {{(ACC_W-PW){w_p[PW-1]}}, w_p};
  end

  logic [TAPS-1:0][ACC_W-1:0] r_s1_mul;
  logic                       r_s1_valid;
  logic                       r_s1_last;
  cfg_t                       r_s1_cfg;
  logic signed [ACC_W-1:0]    r_s1_bias;

  // Capture products and the beat's sideband
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_mul   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_cfg   <= '0;
      r_s1_bias  <= '0;
    end else begin
      r_s1_mul       <= w_mul;
      r_s1_valid     <= in_valid;
      r_s1_last      <= in_valid & in_last;
      r_s1_cfg.relu  <= cfg_relu;
      r_s1_cfg.quan  <= cfg_quan;
      r_s1_cfg.shift <= cfg_shift;
      r_s1_bias      <= bias;
    end
  end

  // ---------------- S2: adder tree ----------------
  logic signed [ACC_W-1:0] w_s2_psum;

  pe_adder_tree #(
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .i_prod (r_s1_mul),
    .o_sum  (w_s2_psum)
  );

  logic                    r_s2_valid;
  logic                    r_s2_last;
  cfg_t                    r_s2_cfg;
  logic signed [ACC_W-1:0] r_s2_bias;

  // Sideband delayed to line up with the tree output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_cfg   <= '0;
      r_s2_bias  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_cfg   <= r_s1_cfg;
      r_s2_bias  <= r_s1_bias;
    end
  end

  // ---------------- S3: channel accumulator ----------------
  acc_state_e              r_state;
  acc_state_e              w_state_d;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_d;
  logic                    r_s3_done;
  cfg_t                    r_s3_cfg;

  // Next accumulator value; bubbles leave state untouched
  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    if (r_s2_valid) begin
      unique case (r_state)
        StFirst: w_acc_d = r_s2_bias + w_s2_psum;
        StAccum: w_acc_d = r_acc + w_s2_psum;
        default: w_acc_d = r_acc;
      endcase
      w_state_d = r_s2_last ? StFirst : StAccum;
    end
  end

  // Accumulator state and the completed-window flag for S4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StFirst;
      r_acc     <= '0;
      r_s3_done <= 1'b0;
      r_s3_cfg  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_acc     <= w_acc_d;
      r_s3_done <= r_s2_valid & r_s2_last;
      if (r_s2_valid && r_s2_last) begin
        r_s3_cfg <= r_s2_cfg;
      end
    end
  end

  // ---------------- S4: ReLU and requantise ----------------
  logic signed [ACC_W-1:0] w_relu;
  quant_t                  w_quant;

  assign w_relu  = (r_s3_cfg.relu && r_acc[ACC_W-1]) ? '0 : r_acc;
  assign w_quant = requant(longint'(w_relu), r_s3_cfg.shift);

  // Output register; data holds between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= r_s3_done;
      if (r_s3_done) begin
        out_data <= r_s3_cfg.quan ? {{(ACC_W-8){1'b0}}, w_quant.q} : w_relu;
        out_sat  <= r_s3_cfg.quan & w_quant.sat;
      end
    end
  end

endmodule

// File: tb/tb_pe_conv_mac.sv
// Self-checking bench for pe_conv_mac: directed cases plus randomized windows
// checked against a window-level arithmetic model.
module tb_pe_conv_mac;

  localparam int TAPS  = 25;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int ACC_W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_last = 1'b0;
  logic [TAPS*DW-1:0]  in_if = '0;
  logic [TAPS*WW-1:0]  in_w = '0;
  logic [ACC_W-1:0]    bias = '0;
  logic                cfg_relu = 1'b0;
  logic                cfg_quan = 1'b0;
  logic [4:0]          cfg_shift = '0;
  logic                out_valid;
  logic [ACC_W-1:0]    out_data;
  logic                out_sat;

  pe_conv_mac #(
    .TAPS  (TAPS),
    .DW    (DW),
    .WW    (WW),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_if     (in_if),
    .in_w      (in_w),
    .bias      (bias),
    .cfg_relu  (cfg_relu),
    .cfg_quan  (cfg_quan),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      cyc;
    logic [31:0] data;
    logic        sat;
  } rec_t;

  rec_t   obs_q[$];
  rec_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  longint m_acc = 0;
  bit     m_open = 1'b0;
  longint last_drive_cyc = 0;

  // Record every output pulse away from the active edge
  always @(negedge clk) begin : mon
    rec_t o;
    if (out_valid === 1'b1) begin
      o.cyc  = cyc;
      o.data = out_data;
      o.sat  = out_sat;
      obs_q.push_back(o);
    end
  end

  function automatic logic [TAPS*DW-1:0] fill_if(input int v);
    logic [TAPS*DW-1:0] res;
    logic [DW-1:0]      b;
    b = v[DW-1:0];
    for (int k = 0; k < TAPS; k++) res[k*DW +: DW] = b;
    return res;
  endfunction

  function automatic logic [TAPS*WW-1:0] fill_w(input int v);
    logic [TAPS*WW-1:0] res;
    logic [WW-1:0]      b;
    b = v[WW-1:0];
    for (int k = 0; k < TAPS; k++) res[k*WW +: WW] = b;
    return res;
  endfunction

  // Drive one beat just after an edge; the model sums the window and, on the
  // last beat, predicts the result due 4 edges after the sampling edge's predecessor.
  task automatic drive_beat(input bit last, input logic [31:0] b, input bit relu, input bit quan,
                            input logic [4:0] sh, input logic [TAPS*DW-1:0] a,
                            input logic [TAPS*WW-1:0] w);
    longint      psum;
    longint      r;
    longint      q;
    bit          sat;
    logic [31:0] d;
    logic [63:0] acc_bits;
    rec_t        e;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_last   = last;
    in_if     = a;
    in_w      = w;
    bias      = b;
    cfg_relu  = relu;
    cfg_quan  = quan;
    cfg_shift = sh;
    last_drive_cyc = cyc;
    psum = 0;
    for (int k = 0; k < TAPS; k++) begin
      psum += longint'(a[k*DW +: DW]) * longint'($signed(w[k*WW +: WW]));
    end
    if (!m_open) m_acc = longint'($signed(b));
    m_acc  += psum;
    m_open = !last;
    if (last) begin
      acc_bits = m_acc;
      r = longint'($signed(acc_bits[31:0]));  // accumulator wraps mod 2^32
      if (relu && r < 0) r = 0;
      sat = 1'b0;
      if (!quan) begin
        d = r[31:0];
      end else begin
        // floor((r + 2^(sh-1)) / 2^sh): round half up
        q = (sh == 0) ? r : ((r + (64'sd1 <<< (sh - 5'd1))) >>> sh);
        if (q < 0) begin
          q = 0;
          sat = 1'b1;
        end else if (q > 255) begin
          q = 255;
          sat = 1'b1;
        end
        d = q[31:0];
      end
      e.cyc  = cyc + 4;
      e.data = d;
      e.sat  = sat;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    in_valid = 1'b1;  // must be ignored while in reset
    in_last  = 1'b1;
    in_if    = fill_if(1);
    in_w     = fill_w(1);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++;
    if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data got %0h want 0", out_data); end
    total++;
    if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got %b want 0", out_sat); end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b0;
    clear_q();
    m_open = 1'b0;
    idle(6);
    total++;
    if (obs_q.size() !== 0) begin bad++; $display("FAIL reset_quiet got %0d pulses want 0", obs_q.size()); end
  endtask

  task automatic test_single();
    longint t;
    clear_q();
    drive_beat(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, fill_if(1), fill_w(1));
    t = last_drive_cyc;
    idle(3);
    total++;
    if (obs_q.size() !== 0) begin bad++; $display("FAIL single_early got %0d pulses want 0", obs_q.size()); end
    idle(4);
    total++;
    if (obs_q.size() !== 1) begin bad++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[0].data !== 32'd25 || obs_q[0].sat !== 1'b0) begin
        bad++; $display("FAIL single_data got %0d sat=%b want 25 sat=0", obs_q[0].data, obs_q[0].sat);
      end
      total++;
      if (obs_q[0].cyc != t + 4) begin
        bad++; $display("FAIL single_latency got cyc %0d want %0d", obs_q[0].cyc, t + 4);
      end
    end
  endtask

  task automatic test_negative();
    logic [31:0] neg;
    neg = -32'sd816000;
    clear_q();
    drive_beat(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, fill_if(255), fill_w(-128));
    drive_beat(1'b1, 32'd0, 1'b1, 1'b0, 5'd0, fill_if(255), fill_w(-128));
    idle(7);
    total++;
    if (obs_q.size() !== 2) begin bad++; $display("FAIL neg_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() > 1) begin
      total++;
      if (obs_q[0].data !== neg || obs_q[0].sat !== 1'b0) begin
        bad++; $display("FAIL neg_norelu got %0h sat=%b want %0h sat=0", obs_q[0].data, obs_q[0].sat, neg);
      end
      total++;
      if (obs_q[1].data !== 32'd0 || obs_q[1].sat !== 1'b0) begin
        bad++; $display("FAIL neg_relu got %0h sat=%b want 0 sat=0", obs_q[1].data, obs_q[1].sat);
      end
    end
  endtask

  task automatic test_multi_beat();
    longint t;
    clear_q();
    drive_beat(1'b0, 32'd10, 1'b0, 1'b0, 5'd0, fill_if(2), fill_w(3));
    drive_beat(1'b0, 32'd999, 1'b0, 1'b0, 5'd0, fill_if(2), fill_w(3));
    idle(2);
    drive_beat(1'b1, 32'd777, 1'b0, 1'b0, 5'd0, fill_if(2), fill_w(3));
    t = last_drive_cyc;
    idle(7);
    total++;
    if (obs_q.size() !== 1) begin bad++; $display("FAIL multi_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[0].data !== 32'd460) begin
        bad++; $display("FAIL multi_data got %0d want 460", obs_q[0].data);
      end
      total++;
      if (obs_q[0].cyc != t + 4) begin
        bad++; $display("FAIL multi_latency got cyc %0d want %0d", obs_q[0].cyc, t + 4);
      end
    end
  endtask

  task automatic test_quant();
    logic [31:0] sums [4];
    logic [31:0] want [4];
    logic        wsat [4];
    sums = '{32'd32639, 32'd40000, 32'd192, -32'sd500};
    want = '{32'd255, 32'd255, 32'd2, 32'd0};
    wsat = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_q();
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, sums[i], 1'b0, 1'b1, 5'd7, fill_if(0), fill_w(0));
    end
    idle(7);
    total++;
    if (obs_q.size() !== 4) begin bad++; $display("FAIL quant_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== want[i] || obs_q[i].sat !== wsat[i]) begin
        bad++;
        $display("FAIL quant_%0d got %0d sat=%b want %0d sat=%b", i, obs_q[i].data, obs_q[i].sat,
                 want[i], wsat[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    longint t;
    clear_q();
    // a complete window still in flight, then an open partial window
    drive_beat(1'b1, 32'd5, 1'b0, 1'b0, 5'd0, fill_if(1), fill_w(1));
    drive_beat(1'b0, 32'd1000, 1'b0, 1'b0, 5'd0, fill_if(1), fill_w(1));
    drive_beat(1'b0, 32'd1000, 1'b0, 1'b0, 5'd0, fill_if(1), fill_w(1));
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_open = 1'b0;
    exp_q.delete();
    drive_beat(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, fill_if(1), fill_w(1));
    t = last_drive_cyc;
    idle(7);
    total++;
    if (obs_q.size() !== 1) begin bad++; $display("FAIL rstmid_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[0].data !== 32'd25 || obs_q[0].cyc != t + 4) begin
        bad++;
        $display("FAIL rstmid_data got %0d at cyc %0d want 25 at cyc %0d", obs_q[0].data,
                 obs_q[0].cyc, t + 4);
      end
    end
  endtask

  task automatic rand_beat(input bit last);
    logic [TAPS*DW-1:0] a;
    logic [TAPS*WW-1:0] w;
    for (int k = 0; k < TAPS; k++) begin
      a[k*DW +: DW] = DW'($urandom);
      w[k*WW +: WW] = WW'($urandom);
    end
    drive_beat(last, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), a, w);
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int i = 0; i < 40; i++) rand_beat(1'b1);
    idle(7);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sat !== exp_q[i].sat ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL b2b_%0d got %0h sat=%b cyc=%0d want %0h sat=%b cyc=%0d", i, obs_q[i].data,
                 obs_q[i].sat, obs_q[i].cyc, exp_q[i].data, exp_q[i].sat, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_random_windows();
    int nb;
    clear_q();
    for (int wdw = 0; wdw < 15; wdw++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        rand_beat(b == nb - 1);
        idle($urandom_range(0, 2));
      end
    end
    idle(7);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rwin_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sat !== exp_q[i].sat ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL rwin_%0d got %0h sat=%b cyc=%0d want %0h sat=%b cyc=%0d", i, obs_q[i].data,
                 obs_q[i].sat, obs_q[i].cyc, exp_q[i].data, exp_q[i].sat, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_multi_beat();
    test_quant();
    test_reset_mid();
    test_back_to_back();
    test_random_windows();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
